// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// opcodes, ALU operation codes, FSM states and instruction classes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SLTU = 5'b01000;
    localparam logic [4:0] ALU_LUI  = 5'b01010;
    localparam logic [4:0] ALU_BGEZ = 5'b10000;
    localparam logic [4:0] ALU_BGTZ = 5'b10001;
    localparam logic [4:0] ALU_BLEZ = 5'b10010;
    localparam logic [4:0] ALU_BLTZ = 5'b10011;
    localparam logic [4:0] ALU_PASS = 5'b11111;

    typedef enum logic [2:0] {
        ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE, CL_ALUI, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_JAL, CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode decoder: maps (op, rt) to instruction class and
// the EXEC-stage ALU controls.
module mc_opdecode
    import mc_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         i_op,
    input  logic [4:0]         i_rt,
    output iclass_t            o_class,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_extop,
    output logic               o_alusrc
);

    logic [4:0] w_alu;
    logic       w_unused_rt;

    // Only rt[0] distinguishes BGEZ from BLTZ.
    assign w_unused_rt = ^i_rt[4:1];

    always_comb begin
        o_class  = CL_ILLEGAL;
        w_alu    = ALU_PASS;
        o_extop  = 1'b0;
        o_alusrc = 1'b0;
        case (i_op)
            OP_RTYPE:  o_class = CL_RTYPE;
            OP_J:      o_class = CL_JUMP;
            OP_JAL:    o_class = CL_JAL;
            OP_REGIMM: begin
                o_class = CL_BRANCH;
                w_alu   = i_rt[0] ? ALU_BGEZ : ALU_BLTZ;
            end
            OP_BEQ, OP_BNE: begin
                o_class = CL_BRANCH;
                w_alu   = ALU_SUB;
            end
            OP_BLEZ: begin o_class = CL_BRANCH; w_alu = ALU_BLEZ; end
            OP_BGTZ: begin o_class = CL_BRANCH; w_alu = ALU_BGTZ; end
            OP_ADDIU: begin o_class = CL_ALUI; w_alu = ALU_ADD;  o_extop = 1'b1; o_alusrc = 1'b1; end
            OP_SLTI:  begin o_class = CL_ALUI; w_alu = ALU_SLT;  o_extop = 1'b1; o_alusrc = 1'b1; end
            OP_SLTIU: begin o_class = CL_ALUI; w_alu = ALU_SLTU; o_extop = 1'b1; o_alusrc = 1'b1; end
            OP_ANDI:  begin o_class = CL_ALUI; w_alu = ALU_AND;  o_alusrc = 1'b1; end
            OP_ORI:   begin o_class = CL_ALUI; w_alu = ALU_OR;   o_alusrc = 1'b1; end
            OP_XORI:  begin o_class = CL_ALUI; w_alu = ALU_XOR;  o_alusrc = 1'b1; end
            OP_LUI:   begin o_class = CL_ALUI; w_alu = ALU_LUI;  o_alusrc = 1'b1; end
            OP_LB, OP_LW, OP_LBU: begin
                o_class = CL_LOAD; w_alu = ALU_ADD; o_extop = 1'b1; o_alusrc = 1'b1;
            end
            OP_SB, OP_SW: begin
                o_class = CL_STORE; w_alu = ALU_ADD; o_extop = 1'b1; o_alusrc = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_aluop = ALUOP_W'(w_alu);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes
// with variable-latency memory and aborts a stalled request after WAIT_MAX cycles.
module mc_control
    import mc_pkg::*;
#(
    parameter int ALUOP_W  = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [4:0]         rt,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic               IRWr,
    output logic               MemRd,
    output logic               MemWr,
    output logic               RegWr,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrc,
    output logic               ExtOp,
    output logic               Link,
    output logic               B,
    output logic               J,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic               bus_err
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_op_q;
    logic [4:0]         r_rt_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [5:0]         w_dec_op;
    logic [4:0]         w_dec_rt;
    iclass_t            w_cls;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_extop;
    logic               w_alusrc;
    logic               w_wait;
    logic               w_tout;

    // DECODE acts on the live IR fields; later states use the latched copy.
    assign w_dec_op = (r_state == ST_DECODE) ? op : r_op_q;
    assign w_dec_rt = (r_state == ST_DECODE) ? rt : r_rt_q;

    mc_opdecode #(.ALUOP_W(ALUOP_W)) u_dec (
        .i_op     (w_dec_op),
        .i_rt     (w_dec_rt),
        .o_class  (w_cls),
        .o_aluop  (w_aluop),
        .o_extop  (w_extop),
        .o_alusrc (w_alusrc)
    );

    assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    assign w_tout = w_wait && (r_cnt == CNT_W'(WAIT_MAX));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BOOT:  w_next = ST_FETCH;
            ST_FETCH: if (mem_ready) w_next = ST_DECODE;
                      else if (w_tout) w_next = ST_FETCH;
            ST_DECODE: case (w_cls)
                CL_JUMP, CL_ILLEGAL: w_next = ST_FETCH;
                CL_JAL:              w_next = ST_WB;
                default:             w_next = ST_EXEC;
            endcase
            ST_EXEC: case (w_cls)
                CL_RTYPE, CL_ALUI:  w_next = ST_WB;
                CL_LOAD, CL_STORE:  w_next = ST_MEM;
                default:            w_next = ST_FETCH;
            endcase
            ST_MEM: if (mem_ready) w_next = (w_cls == CL_LOAD) ? ST_WB : ST_FETCH;
                    else if (w_tout) w_next = ST_FETCH;
            ST_WB:   w_next = ST_FETCH;
            default: w_next = ST_BOOT;
        endcase
    end

    // Every non-waiting cycle enters a state (possibly FETCH again), so the counter clears there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_op_q  <= '0;
            r_rt_q  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_wait && !w_tout) ? r_cnt + CNT_W'(1) : '0;
            if (r_state == ST_DECODE) begin
                r_op_q <= op;
                r_rt_q <= rt;
            end
        end
    end

    // Outputs decode the registered state; FETCH strobes and bus_err also see mem_ready.
    always_comb begin
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ExtOp    = 1'b0;
        Link     = 1'b0;
        B        = 1'b0;
        J        = 1'b0;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        ALUop    = ALUOP_W'(ALU_PASS);
        case (r_state)
            ST_BOOT: ALUop = '0;
            ST_FETCH: begin
                MemRd   = 1'b1;
                IRWr    = mem_ready;
                PCWr    = mem_ready;
                bus_err = w_tout;
            end
            ST_DECODE: case (w_cls)
                CL_JUMP, CL_JAL: begin J = 1'b1; PCWr = 1'b1; end
                CL_ILLEGAL:      illegal = 1'b1;
                default: ;
            endcase
            ST_EXEC: begin
                ALUop  = w_aluop;
                ALUSrc = w_alusrc;
                ExtOp  = w_extop;
                if (w_cls == CL_BRANCH) begin
                    B    = 1'b1;
                    PCWr = 1'b1;
                end
            end
            ST_MEM: begin
                MemRd   = (w_cls == CL_LOAD);
                MemWr   = (w_cls == CL_STORE);
                bus_err = w_tout;
            end
            ST_WB: begin
                RegWr    = 1'b1;
                RegDst   = (w_cls == CL_RTYPE);
                MemtoReg = (w_cls == CL_LOAD);
                Link     = (w_cls == CL_JAL);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main control unit for the 36-instruction MIPS core, replacing the single-cycle combinational decoder. It latches the opcode and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, driving datapath enables per state. It also handshakes with a variable-latency memory, including a wait-timeout, and resolves REGIMM branches (BGEZ/BLTZ) from the rt field. It sits between the instruction register and the datapath muxes/write enables.

## Interface
- ALUOP_W, 5: ALUop width; must be ≥5.
- WAIT_MAX, 15: maximum cycles spent waiting on `mem_ready` before the block aborts.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode from the IR, sampled in DECODE.
- rt  in  5  IR rt field, sampled in DECODE; selects the REGIMM variant.
- mem_ready  in  1  memory completion for the current MemRd/MemWr.
- PCWr, IRWr  out  1  PC update and IR load strobes.
- MemRd, MemWr  out  1  memory request strobes, held until completion.
- RegWr, RegDst, MemtoReg, ALUSrc, ExtOp, Link  out  1  datapath controls. `Link` selects r31/PC+8 for JAL.
- B, J  out  1  branch-evaluate and jump strobes.
- ALUop  out  ALUOP_W  ALU operation code.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  one-cycle pulse on a `mem_ready` timeout.

## Operation
- **States:** BOOT, FETCH, DECODE, EXEC, MEM, WB.
  - Reset state is BOOT. BOOT lasts 1 cycle with all outputs 0, then goes to FETCH.
- **FETCH:** MemRd=1.
  - When `mem_ready`=1: IRWr=PCWr=1 in that same cycle, then go to DECODE.
- **DECODE:** latch `op` into op_q and `rt` into rt_q. Next state depends on class:
  - J (000010): J=1 and PCWr=1 in DECODE, then FETCH.
  - JAL (000011): J=1 and PCWr=1 in DECODE, then WB with Link=1.
  - Undefined op: `illegal` pulses, then FETCH. No other outputs are asserted.
  - All other defined ops: go to EXEC.
- **EXEC:** ALUop, ALUSrc and ExtOp are driven from op_q. Next state:
  - R-type (000000) and immediate ALU ops (ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI): WB.
  - Loads (LW, LB, LBU) and stores (SW, SB): MEM.
  - Branches (BEQ, BNE, BGTZ, BLEZ, REGIMM): B=1, PCWr=1, then FETCH.
- **REGIMM (000001):** rt_q[0]=1 gives BGEZ (ALUop 10000); rt_q[0]=0 gives BLTZ (ALUop 10011).
- **MEM:**
  - Loads: MemRd=1 until `mem_ready`, then WB.
  - Stores: MemWr=1 until `mem_ready`, then FETCH.
- **WB:** RegWr=1 for one cycle, then FETCH.
  - RegDst=1 only for R-type.
  - MemtoReg=1 only for loads.
- **ALUop codes** (zero-extended to ALUOP_W):
  - ADD 00000 (ADDIU and all memory ops), SUB 00001 (BEQ/BNE), SLT 00010, AND 00011, OR 00101, XOR 00110, SLTU 01000, LUI 01010.
  - BGEZ 10000, BGTZ 10001, BLEZ 10010, BLTZ 10011.
  - Pass-through 11111 for R-type/J and in all non-EXEC states.
- **ExtOp=1** (sign-extend) for ADDIU, SLTI, SLTIU, loads and stores. ExtOp=0 otherwise.
- **Timeout:** a wait counter (width clog2(WAIT_MAX+1)) clears on every state entry and increments each FETCH/MEM cycle without `mem_ready`.
  - When the count reaches WAIT_MAX: `bus_err` pulses, the request drops, the next state is FETCH, and no IRWr/RegWr is issued.

## Timing
- Cycle counts:
  - R/ALU-imm: 4 cycles + fetch waits.
  - Load: 5 cycles + waits.
  - Store: 4 cycles + waits.
  - Branch: 3 cycles.
  - J: 2 cycles.
  - JAL: 3 cycles.
- Most outputs are decoded from state, op_q and rt_q only (Moore).
  - Exceptions: IRWr/PCWr in FETCH and the MEM exit are qualified combinationally by `mem_ready`.
- `mem_ready` is ignored in every state other than FETCH and MEM.
- `mem_ready` arriving in the same cycle the counter reaches WAIT_MAX counts as success; there is no `bus_err`.
- Asynchronous reset mid-instruction: state returns to BOOT immediately, op_q=rt_q=0, the counter clears, and all outputs go to 0 in the same cycle.

## Structure
- Package `mc_pkg` holds:
  - opcode localparams;
  - ALUop code constants;
  - state enum;
  - instruction-class enum (RTYPE, ALUI, LOAD, STORE, BRANCH, JUMP, JAL, ILLEGAL).
- One combinational sub-module, `mc_opdecode`, maps (op_q, rt_q) to {class, ALUop, ExtOp, ALUSrc}. The FSM and wait counter live in `mc_control`.

## Test plan
- ADDIU (001001), `mem_ready` tied 1:
  - BOOT→FETCH→DECODE→EXEC→WB.
  - ALUop=00000, ExtOp=1, ALUSrc=1 in EXEC; RegWr=1, RegDst=0 in WB.
  - Exactly 4 cycles from FETCH to the next FETCH.
- LW with `mem_ready` low for 3 MEM cycles: MemRd held 4 cycles in MEM, then WB with MemtoReg=1 and RegWr=1.
- op=000001 with rt=00001 gives ALUop=10000. With rt=00000 it gives ALUop=10011. B=1 and PCWr=1 in EXEC in both cases.
- op=111111: `illegal` pulses once in DECODE; RegWr, MemWr and PCWr stay 0; back to FETCH.
- WAIT_MAX=4 with `mem_ready` stuck low in FETCH: `bus_err` pulses after 4 wait cycles, IRWr never asserts, FETCH restarts.
- rst_n asserted while SW is in MEM: MemWr drops in the same cycle. After release, BOOT for 1 cycle, then FETCH with MemRd=1.
